// File: rtl/map_table_ckpt.sv
`default_nettype none
// ============================================================================
// Module   : map_table_ckpt
// Purpose  : Register rename map table. Holds a speculative map, a committed
//            map, per-PR ready bits and a circular queue of branch snapshots
//            used for mispredict recovery.
// Revision : 1.0 - initial release
// ============================================================================
module map_table_ckpt #(
    parameter  int NUM_ARCH = 32,
    parameter  int NUM_PHYS = 64,
    parameter  int RW       = 2,
    parameter  int CDB_W    = 2,
    parameter  int NUM_CKPT = 4,
    localparam int AW       = $clog2(NUM_ARCH),
    localparam int PW       = $clog2(NUM_PHYS),
    localparam int CW       = $clog2(NUM_CKPT)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [RW-1:0]       ren_valid,
    input  logic [RW*AW-1:0]    ren_src1,
    input  logic [RW*AW-1:0]    ren_src2,
    input  logic [RW*AW-1:0]    ren_dest,
    input  logic [RW*PW-1:0]    ren_new_pr,
    output logic [RW*PW-1:0]    src1_pr,
    output logic [RW*PW-1:0]    src2_pr,
    output logic [RW-1:0]       src1_ready,
    output logic [RW-1:0]       src2_ready,
    output logic [RW*PW-1:0]    old_dest_pr,
    input  logic [CDB_W-1:0]    cdb_valid,
    input  logic [CDB_W*PW-1:0] cdb_pr,
    input  logic [RW-1:0]       ret_valid,
    input  logic [RW*AW-1:0]    ret_arch,
    input  logic [RW*PW-1:0]    ret_pr,
    input  logic                ckpt_req,
    output logic [CW-1:0]       ckpt_tag,
    output logic                ckpt_full,
    input  logic                ckpt_free,
    input  logic                recover_valid,
    input  logic [CW-1:0]       recover_tag,
    input  logic                flush,
    input  logic [AW-1:0]       arch_rd_idx,
    output logic [PW-1:0]       arch_rd_pr
);

    localparam int              CNTW        = $clog2(NUM_CKPT + 1);
    localparam logic [CW-1:0]   c_LAST_SLOT = CW'(NUM_CKPT - 1);
    localparam logic [CNTW-1:0] c_FULL_CNT  = CNTW'(NUM_CKPT);

    // Architectural state
    logic [PW-1:0]       r_spec [NUM_ARCH];
    logic [PW-1:0]       r_arch [NUM_ARCH];
    logic [NUM_PHYS-1:0] r_rdy;
    logic [PW-1:0]       r_ckpt [NUM_CKPT][NUM_ARCH];
    logic [CW-1:0]       r_head;
    logic [CW-1:0]       r_tail;
    logic [CNTW-1:0]     r_count;

    // Next-state views
    logic [PW-1:0]       w_spec_ren [NUM_ARCH];
    logic [PW-1:0]       w_arch_nxt [NUM_ARCH];
    logic [NUM_PHYS-1:0] w_rdy_cdb;
    logic [NUM_PHYS-1:0] w_rdy_ren;
    logic                w_ckpt_do;
    logic                w_free_do;
    logic [CW-1:0]       w_tail_inc;
    logic [CW-1:0]       w_head_inc;
    logic [CNTW-1:0]     w_rec_count;

    // Per-lane lookup ports: 0 = src1, 1 = src2, 2 = old dest
    logic [AW-1:0]       w_q_idx [RW][3];
    logic [PW-1:0]       w_q_pr  [RW][3];
    logic                w_q_byp [RW][3];
    logic                w_q_rdy [RW][3];

    // Gather the three arch indices each lane looks up
    always_comb begin
        for (int j = 0; j < RW; j++) begin
            w_q_idx[j][0] = ren_src1[j*AW +: AW];
            w_q_idx[j][1] = ren_src2[j*AW +: AW];
            w_q_idx[j][2] = ren_dest[j*AW +: AW];
        end
    end

    // Map lookup with bypass from older lanes of the same rename group
    always_comb begin
        for (int j = 0; j < RW; j++) begin
            for (int p = 0; p < 3; p++) begin
                w_q_pr[j][p]  = r_spec[w_q_idx[j][p]];
                w_q_byp[j][p] = 1'b0;
                // Ascending scan so the youngest older lane wins
                for (int i = 0; i < RW; i++) begin
                    if (i < j && ren_valid[i] && w_q_idx[j][p] != '0 &&
                        ren_dest[i*AW +: AW] == w_q_idx[j][p]) begin
                        w_q_pr[j][p]  = ren_new_pr[i*PW +: PW];
                        w_q_byp[j][p] = 1'b1;
                    end
                end
                w_q_rdy[j][p] = r_rdy[w_q_pr[j][p]];
                for (int c = 0; c < CDB_W; c++) begin
                    if (cdb_valid[c] && cdb_pr[c*PW +: PW] == w_q_pr[j][p]) begin
                        w_q_rdy[j][p] = 1'b1;
                    end
                end
                // A PR produced inside this group cannot be complete yet
                if (w_q_byp[j][p]) begin
                    w_q_rdy[j][p] = 1'b0;
                end
                if (w_q_idx[j][p] == '0) begin
                    w_q_pr[j][p]  = '0;
                    w_q_rdy[j][p] = 1'b1;
                end
            end
        end
    end

    // Pack lookup results onto the lane buses
    always_comb begin
        for (int j = 0; j < RW; j++) begin
            src1_pr[j*PW +: PW]     = w_q_pr[j][0];
            src2_pr[j*PW +: PW]     = w_q_pr[j][1];
            old_dest_pr[j*PW +: PW] = w_q_pr[j][2];
            src1_ready[j]           = w_q_rdy[j][0];
            src2_ready[j]           = w_q_rdy[j][1];
        end
    end

    // Speculative map after this cycle's renames (highest lane wins)
    always_comb begin
        w_spec_ren = r_spec;
        for (int i = 0; i < RW; i++) begin
            if (ren_valid[i] && ren_dest[i*AW +: AW] != '0) begin
                w_spec_ren[ren_dest[i*AW +: AW]] = ren_new_pr[i*PW +: PW];
            end
        end
    end

    // Committed map after this cycle's retires (highest lane wins)
    always_comb begin
        w_arch_nxt = r_arch;
        for (int k = 0; k < RW; k++) begin
            if (ret_valid[k] && ret_arch[k*AW +: AW] != '0) begin
                w_arch_nxt[ret_arch[k*AW +: AW]] = ret_pr[k*PW +: PW];
            end
        end
    end

    // Ready bits: CDB sets first, then rename clears override
    always_comb begin
        w_rdy_cdb = r_rdy;
        for (int c = 0; c < CDB_W; c++) begin
            if (cdb_valid[c]) begin
                w_rdy_cdb[cdb_pr[c*PW +: PW]] = 1'b1;
            end
        end
        w_rdy_ren = w_rdy_cdb;
        for (int i = 0; i < RW; i++) begin
            if (ren_valid[i] && ren_dest[i*AW +: AW] != '0) begin
                w_rdy_ren[ren_new_pr[i*PW +: PW]] = 1'b0;
            end
        end
    end

    assign arch_rd_pr  = w_arch_nxt[arch_rd_idx];
    assign ckpt_tag    = r_tail;
    assign ckpt_full   = (r_count == c_FULL_CNT);
    assign w_ckpt_do   = ckpt_req && !ckpt_full;
    assign w_free_do   = ckpt_free && (r_count != '0);
    assign w_tail_inc  = (r_tail == c_LAST_SLOT) ? '0 : r_tail + CW'(1);
    assign w_head_inc  = (r_head == c_LAST_SLOT) ? '0 : r_head + CW'(1);
    // Live slots from head up to (not including) the recovered tag
    assign w_rec_count = (recover_tag >= r_head) ?
                         CNTW'(recover_tag) - CNTW'(r_head) :
                         CNTW'(recover_tag) + c_FULL_CNT - CNTW'(r_head);

    // Map, ready and queue-pointer update with flush > recover > normal
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ARCH; i++) begin
                r_spec[i] <= PW'(i);
                r_arch[i] <= PW'(i);
            end
            r_rdy   <= '1;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_arch <= w_arch_nxt;
            if (flush) begin
                r_spec  <= w_arch_nxt;
                r_rdy   <= '1;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else if (recover_valid) begin
                r_spec  <= r_ckpt[recover_tag];
                r_rdy   <= w_rdy_cdb;
                r_tail  <= recover_tag;
                r_count <= w_rec_count;
            end else begin
                r_spec  <= w_spec_ren;
                r_rdy   <= w_rdy_ren;
                if (w_ckpt_do) begin
                    r_tail <= w_tail_inc;
                end
                if (w_free_do) begin
                    r_head <= w_head_inc;
                end
                r_count <= r_count + CNTW'(w_ckpt_do) - CNTW'(w_free_do);
            end
        end
    end

    // Snapshot storage; contents are only meaningful while a slot is live
    always_ff @(posedge clk) begin
        if (reset && !flush && !recover_valid && w_ckpt_do) begin
            r_ckpt[r_tail] <= w_spec_ren;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_map_table_ckpt.sv
`default_nettype none
// ============================================================================
// Module   : tb_map_table_ckpt
// Purpose  : Directed self-checking bench for map_table_ckpt.
// Revision : 1.0 - initial release
// ============================================================================
module tb_map_table_ckpt;

    localparam int AW = 5;
    localparam int PW = 6;
    localparam int CW = 2;
    localparam int RW = 2;
    localparam int CDB_W = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic [RW-1:0]       ren_valid;
    logic [RW*AW-1:0]    ren_src1, ren_src2, ren_dest;
    logic [RW*PW-1:0]    ren_new_pr;
    logic [RW*PW-1:0]    src1_pr, src2_pr, old_dest_pr;
    logic [RW-1:0]       src1_ready, src2_ready;
    logic [CDB_W-1:0]    cdb_valid;
    logic [CDB_W*PW-1:0] cdb_pr;
    logic [RW-1:0]       ret_valid;
    logic [RW*AW-1:0]    ret_arch;
    logic [RW*PW-1:0]    ret_pr;
    logic                ckpt_req, ckpt_full, ckpt_free;
    logic [CW-1:0]       ckpt_tag;
    logic                recover_valid;
    logic [CW-1:0]       recover_tag;
    logic                flush;
    logic [AW-1:0]       arch_rd_idx;
    logic [PW-1:0]       arch_rd_pr;

    int n_cmp = 0;
    int n_err = 0;

    map_table_ckpt dut (
        .clk(clk), .reset(reset),
        .ren_valid(ren_valid), .ren_src1(ren_src1), .ren_src2(ren_src2),
        .ren_dest(ren_dest), .ren_new_pr(ren_new_pr),
        .src1_pr(src1_pr), .src2_pr(src2_pr),
        .src1_ready(src1_ready), .src2_ready(src2_ready),
        .old_dest_pr(old_dest_pr),
        .cdb_valid(cdb_valid), .cdb_pr(cdb_pr),
        .ret_valid(ret_valid), .ret_arch(ret_arch), .ret_pr(ret_pr),
        .ckpt_req(ckpt_req), .ckpt_tag(ckpt_tag), .ckpt_full(ckpt_full),
        .ckpt_free(ckpt_free),
        .recover_valid(recover_valid), .recover_tag(recover_tag),
        .flush(flush),
        .arch_rd_idx(arch_rd_idx), .arch_rd_pr(arch_rd_pr)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        ren_valid = '0; ren_src1 = '0; ren_src2 = '0; ren_dest = '0; ren_new_pr = '0;
        cdb_valid = '0; cdb_pr = '0;
        ret_valid = '0; ret_arch = '0; ret_pr = '0;
        ckpt_req = 1'b0; ckpt_free = 1'b0;
        recover_valid = 1'b0; recover_tag = '0;
        flush = 1'b0; arch_rd_idx = '0;
    endtask

    task automatic ren(input int l, input int s1, input int s2, input int d, input int np);
        ren_valid[l]          = 1'b1;
        ren_src1[l*AW +: AW]  = AW'(s1);
        ren_src2[l*AW +: AW]  = AW'(s2);
        ren_dest[l*AW +: AW]  = AW'(d);
        ren_new_pr[l*PW +: PW] = PW'(np);
    endtask

    task automatic rd(input int l, input int s1, input int s2);
        ren_src1[l*AW +: AW] = AW'(s1);
        ren_src2[l*AW +: AW] = AW'(s2);
    endtask

    task automatic ret(input int l, input int a, input int p);
        ret_valid[l]         = 1'b1;
        ret_arch[l*AW +: AW] = AW'(a);
        ret_pr[l*PW +: PW]   = PW'(p);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] s1p(input int l); return 32'(src1_pr[l*PW +: PW]); endfunction
    function automatic logic [31:0] s2p(input int l); return 32'(src2_pr[l*PW +: PW]); endfunction
    function automatic logic [31:0] odp(input int l); return 32'(old_dest_pr[l*PW +: PW]); endfunction

    initial begin
        clr();
        // Reset held while a full-width rename is presented: rename must be ignored
        reset = 1'b0;
        ren(0, 0, 0, 3, 20);
        ren(1, 0, 0, 4, 21);
        ret(0, 4, 22);
        tick(); tick();
        reset = 1'b1;
        clr();
        rd(0, 5, 3); rd(1, 4, 0);
        arch_rd_idx = 5'd9;
        #1;
        chk("rst_src1_pr", s1p(0), 5);
        chk("rst_src1_rdy", 32'(src1_ready[0]), 1);
        chk("rst_src2_pr", s2p(0), 3);
        chk("rst_l1_src1_pr", s1p(1), 4);
        chk("rst_ckpt_tag", 32'(ckpt_tag), 0);
        chk("rst_ckpt_full", 32'(ckpt_full), 0);
        chk("rst_arch_rd", 32'(arch_rd_pr), 9);
        arch_rd_idx = 5'd4;
        #1;
        chk("rst_arch_rd4", 32'(arch_rd_pr), 4);

        // Intra-group bypass: lane0 r3->40, lane1 reads r3 and renames r3->41
        clr();
        ren(0, 1, 0, 3, 40);
        ren(1, 3, 0, 3, 41);
        #1;
        chk("byp_l1_src1_pr", s1p(1), 40);
        chk("byp_l1_src1_rdy", 32'(src1_ready[1]), 0);
        chk("byp_l1_old_dest", odp(1), 40);
        chk("byp_l0_old_dest", odp(0), 3);
        chk("byp_l0_src1_rdy", 32'(src1_ready[0]), 1);
        tick();
        clr();
        rd(0, 3, 0);
        #1;
        chk("byp_spec3", s1p(0), 41);
        chk("byp_spec3_rdy", 32'(src1_ready[0]), 0);

        // CDB wakeup: r5->50, then broadcast 50 while reading r5
        clr();
        ren(0, 0, 0, 5, 50);
        tick();
        clr();
        rd(0, 5, 0);
        #1;
        chk("cdb_pre_rdy", 32'(src1_ready[0]), 0);
        chk("cdb_pre_pr", s1p(0), 50);
        cdb_valid[1] = 1'b1; cdb_pr[1*PW +: PW] = 6'd50;
        #1;
        chk("cdb_same_cycle_rdy", 32'(src1_ready[0]), 1);
        tick();
        clr();
        rd(0, 5, 0);
        #1;
        chk("cdb_after_rdy", 32'(src1_ready[0]), 1);

        // Rename clear beats CDB set of the same PR in the same cycle
        clr();
        ren(0, 0, 0, 6, 52);
        cdb_valid[0] = 1'b1; cdb_pr[0 +: PW] = 6'd52;
        tick();
        clr();
        rd(0, 6, 0);
        #1;
        chk("clr_wins_pr", s1p(0), 52);
        chk("clr_wins_rdy", 32'(src1_ready[0]), 0);

        // Fill all four checkpoint slots
        for (int t = 0; t < 4; t++) begin
            clr();
            ckpt_req = 1'b1;
            #1;
            chk($sformatf("fill_tag%0d", t), 32'(ckpt_tag), 32'(t));
            tick();
        end
        clr();
        #1;
        chk("fill_full", 32'(ckpt_full), 1);
        chk("fill_tag_wrap", 32'(ckpt_tag), 0);
        ckpt_req = 1'b1;
        tick();
        clr();
        #1;
        chk("fifth_ignored_full", 32'(ckpt_full), 1);
        chk("fifth_ignored_tag", 32'(ckpt_tag), 0);
        ckpt_free = 1'b1;
        tick();
        clr();
        #1;
        chk("free_full", 32'(ckpt_full), 0);
        chk("free_tag", 32'(ckpt_tag), 0);

        // Flush restores committed (identity) map and empties the queue
        flush = 1'b1;
        tick();
        clr();
        rd(0, 3, 6);
        #1;
        chk("flush_spec3", s1p(0), 3);
        chk("flush_spec6_rdy", 32'(src2_ready[0]), 1);
        chk("flush_tag", 32'(ckpt_tag), 0);

        // Checkpoint/recover: tag0, r7->60, tag1, r7->61, recover tag1
        ckpt_req = 1'b1;
        tick();
        clr();
        ren(0, 0, 0, 7, 60);
        tick();
        clr();
        ckpt_req = 1'b1;
        #1;
        chk("rec_tag_before", 32'(ckpt_tag), 1);
        tick();
        clr();
        ren(0, 0, 0, 7, 61);
        tick();
        clr();
        rd(0, 7, 0);
        #1;
        chk("rec_spec7_pre", s1p(0), 61);
        recover_valid = 1'b1; recover_tag = 2'd1;
        ren(1, 0, 0, 8, 62);
        tick();
        clr();
        rd(0, 7, 8);
        #1;
        chk("rec_spec7", s1p(0), 60);
        chk("rec_rename_dropped", s2p(0), 8);
        chk("rec_tag", 32'(ckpt_tag), 1);
        chk("rec_full", 32'(ckpt_full), 0);
        // count==1: two more requests leave it short of full, a third fills it
        ckpt_req = 1'b1;
        tick(); tick();
        #1;
        chk("rec_cnt3_full", 32'(ckpt_full), 0);
        chk("rec_cnt3_tag", 32'(ckpt_tag), 3);
        tick();
        clr();
        #1;
        chk("rec_cnt4_full", 32'(ckpt_full), 1);
        flush = 1'b1;
        tick();
        clr();

        // Retire r2->33 in the same cycle as flush; PR33 not ready beforehand
        ren(0, 0, 0, 9, 33);
        tick();
        clr();
        ret(0, 2, 33);
        flush = 1'b1;
        arch_rd_idx = 5'd2;
        #1;
        chk("ret_bypass_rd", 32'(arch_rd_pr), 33);
        tick();
        clr();
        rd(0, 2, 9);
        arch_rd_idx = 5'd2;
        #1;
        chk("flush_ret_spec2", s1p(0), 33);
        chk("flush_ret_rdy", 32'(src1_ready[0]), 1);
        chk("flush_ret_spec9", s2p(0), 9);
        chk("flush_ret_arch2", 32'(arch_rd_pr), 33);
        chk("flush_ret_full", 32'(ckpt_full), 0);

        // Two lanes retiring the same arch reg: highest lane wins
        ret(0, 4, 44); ret(1, 4, 45);
        arch_rd_idx = 5'd4;
        #1;
        chk("ret_dup_bypass", 32'(arch_rd_pr), 45);
        tick();
        clr();
        ret(0, 0, 50);
        arch_rd_idx = 5'd4;
        #1;
        chk("ret_dup_after", 32'(arch_rd_pr), 45);
        arch_rd_idx = 5'd0;
        #1;
        chk("ret_r0_ignored", 32'(arch_rd_pr), 0);
        tick();
        clr();

        // Rename to arch reg 0 is ignored and never bypasses
        ren(0, 0, 0, 0, 55);
        ren(1, 0, 0, 11, 56);
        #1;
        chk("r0_l1_src_pr", s1p(1), 0);
        chk("r0_l1_src_rdy", 32'(src1_ready[1]), 1);
        tick();
        clr();
        rd(0, 0, 0);
        #1;
        chk("r0_after", s1p(0), 0);

        // Reset asserted mid-rename with both lanes valid
        reset = 1'b0;
        ren(0, 0, 0, 5, 57);
        ren(1, 0, 0, 6, 58);
        tick();
        reset = 1'b1;
        clr();
        rd(0, 5, 6);
        rd(1, 11, 7);
        arch_rd_idx = 5'd4;
        #1;
        chk("rst2_spec5", s1p(0), 5);
        chk("rst2_spec6", s2p(0), 6);
        chk("rst2_spec11", s1p(1), 11);
        chk("rst2_spec6_rdy", 32'(src2_ready[0]), 1);
        chk("rst2_arch4", 32'(arch_rd_pr), 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/map_table_ckpt.md
MAP_TABLE_CKPT -- requirements
Module: map_table_ckpt

Interface
REQ-001 SHALL take parameters (name, default, meaning): NUM_ARCH, 32, architectural registers; NUM_PHYS, 64, physical registers; RW, 2, rename/retire lanes; CDB_W, 2, CDB broadcast ports; NUM_CKPT, 4, branch checkpoint slots.
REQ-002 SHALL derive AW=$clog2(NUM_ARCH), PW=$clog2(NUM_PHYS), CW=$clog2(NUM_CKPT); lane k occupies bits [k*W +: W] of every packed lane bus.
REQ-003 SHALL have ports (name direction width meaning):
- clk in 1 clock; reset in 1 synchronous, active-low reset
- ren_valid in RW per-lane rename valid; ren_src1/ren_src2/ren_dest in RW*AW arch indices
- ren_new_pr in RW*PW newly allocated PR per lane
- src1_pr/src2_pr out RW*PW mapped source PRs; src1_ready/src2_ready out RW source ready bits
- old_dest_pr out RW*PW prior mapping of ren_dest (for freeing at retire)
- cdb_valid in CDB_W; cdb_pr in CDB_W*PW completing PRs
- ret_valid in RW; ret_arch in RW*AW; ret_pr in RW*PW committed mappings
- ckpt_req in 1 save snapshot; ckpt_tag out CW tag of next snapshot; ckpt_full out 1 no free slot
- ckpt_free in 1 release oldest checkpoint (branch resolved correct)
- recover_valid in 1; recover_tag in CW mispredict, restore that snapshot
- flush in 1 restore committed (arch) map, drop all checkpoints
- arch_rd_idx in AW; arch_rd_pr out PW committed map read port

Function
REQ-004 SHALL hold speculative map spec[NUM_ARCH], committed map arch[NUM_ARCH], ready vector rdy[NUM_PHYS], NUM_CKPT snapshots of spec, circular head/tail pointers and count.
REQ-005 Arch reg 0 SHALL always read PR 0, ready=1; writes to arch reg 0 (rename or retire) ignored.
REQ-006 Rename reads SHALL be combinational: lane j source/old_dest = ren_new_pr of highest lane i<j with ren_valid[i] and ren_dest[i]==index (nonzero), else spec[index].
REQ-007 Intra-group-bypassed source SHALL report ready=0; otherwise ready = rdy[pr] OR any cdb_valid[c] with cdb_pr[c]==pr this cycle.
REQ-008 On clock edge, each valid lane SHALL write spec[ren_dest]=ren_new_pr and clear rdy[ren_new_pr]; same dest in several lanes: highest lane wins.
REQ-009 Each cdb_valid[c] SHALL set rdy[cdb_pr[c]] next cycle; rename clear of same PR same cycle wins.
REQ-010 Each ret_valid[k] SHALL write arch[ret_arch[k]]=ret_pr[k]; same arch index: highest lane wins.
REQ-011 arch_rd_pr SHALL return arch[arch_rd_idx] with same-cycle retire bypass.
REQ-012 ckpt_req with !ckpt_full SHALL store into slot tail the spec map including this cycle's renames, then tail=tail+1 mod NUM_CKPT, count+1; with ckpt_full, ignored, no state change.
REQ-013 ckpt_tag SHALL equal tail; ckpt_full SHALL equal (count==NUM_CKPT).
REQ-014 ckpt_free with count>0 SHALL advance head mod NUM_CKPT, count-1; with count==0 ignored; concurrent ckpt_req and ckpt_free both apply.
REQ-015 recover_valid SHALL copy slot recover_tag into spec, set tail=recover_tag, count=(recover_tag-head) mod NUM_CKPT (frees that and all younger slots); recover_tag outside live range is illegal.
REQ-016 flush SHALL copy arch (including same-cycle retires) into spec, set all rdy=1, head=tail=count=0.
REQ-017 Priority SHALL be flush > recover_valid > (rename, ckpt_req, ckpt_free); lower-priority updates in that cycle dropped; retire and CDB always apply.
REQ-018 All state updates SHALL be visible in combinational outputs the cycle after the edge.

Reset
REQ-019 While reset==0 at posedge clk: spec[i]=arch[i]=i, rdy all 1, head=tail=count=0; outputs then read ckpt_tag=0, ckpt_full=0, src*_pr=src index, src*_ready=1.
REQ-020 Reset SHALL override any concurrent rename, retire, CDB, checkpoint, recover or flush.

Verification
REQ-021 Lane0 r3->PR40, lane1 src1=r3, dest r3->PR41 -> lane1 src1_pr=40 ready=0, old_dest_pr=40; next cycle spec[3]=41.
REQ-022 Rename r5->PR50; later CDB PR50 same cycle as read of r5 -> src1_ready=1 that cycle, rdy[50]=1 thereafter.
REQ-023 Four ckpt_req (tags 0..3) -> ckpt_full=1; fifth ignored; ckpt_free -> ckpt_full=0, ckpt_tag=0.
REQ-024 Ckpt tag1 after r7->PR60, then r7->PR61, recover tag1 -> spec[7]=60, ckpt_tag=1, count=1.
REQ-025 Retire r2->PR33 with flush same cycle -> spec[2]=33, all rdy=1, count=0.
REQ-026 reset asserted mid-rename with ren_valid=11 -> all maps identity, rename ignored.
